// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle add/sub/logic ops plus an iterative restoring
// divider for div/mod. The result is held until the consumer accepts it.
module iter_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and ready depends only on the state register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
    logic             mod_q;
    logic [WIDTH:0]   out_q;
    logic             zero_q, dbz_q;

    logic             accept, is_divop, div_path, last_step;
    logic [WIDTH:0]   single_res;
    logic             single_dbz;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff, rem_nx, quo_nx;
    logic             fits;
    logic [WIDTH:0]   res_nx;
    logic             dbz_nx, load;

    assign accept    = in_valid && (state == IDLE);
    assign is_divop  = (select == 3'b010) || (select == 3'b011);
    assign div_path  = is_divop && (in2 != '0);
    assign last_step = (cnt == CW'(WIDTH - 1));

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state == DIV);
    assign out         = out_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = div_path ? DIV : DONE;
            DIV:     if (last_step) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        single_res = '0;
        single_dbz = 1'b0;
        case (select)
            3'b000: single_res = {1'b0, in1} + {1'b0, in2};
            3'b001: single_res = {1'b0, in1} - {1'b0, in2};
            3'b010: begin
                single_res = {1'b0, {WIDTH{1'b1}}};
                single_dbz = 1'b1;
            end
            3'b011: begin
                single_res = {1'b0, in1};
                single_dbz = 1'b1;
            end
            3'b100: single_res = {1'b0, in1 & in2};
            3'b101: single_res = {1'b0, in1 | in2};
            3'b110: single_res = {1'b0, in1 ^ in2};
            default: single_res = {1'b0, ~(in1 ^ in2)};
        endcase
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits; the quotient bit records the outcome.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dsr_q});
        diff    = shifted[WIDTH-1:0] - dsr_q;
        rem_nx  = fits ? diff : shifted[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], fits};
    end

    always_comb begin
        res_nx = single_res;
        dbz_nx = single_dbz;
        load   = 1'b0;
        if (state == IDLE) begin
            load = accept && !div_path;
        end else if (state == DIV) begin
            res_nx = mod_q ? {1'b0, rem_nx} : {1'b0, quo_nx};
            dbz_nx = 1'b0;
            load   = last_step;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            mod_q  <= 1'b0;
            out_q  <= '0;
            zero_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            if (accept) begin
                quo_q <= in1;
                dsr_q <= in2;
                rem_q <= '0;
                cnt   <= '0;
                mod_q <= select[0];
            end else if (state == DIV) begin
                quo_q <= quo_nx;
                rem_q <= rem_nx;
                cnt   <= cnt + CW'(1);
            end
            if (load) begin
                out_q  <= res_nx;
                zero_q <= (res_nx[WIDTH-1:0] == '0);
                dbz_q  <= dbz_nx;
            end
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: arithmetic model with an expected-result queue,
// per-cycle output checks, latency/busy/backpressure checks and literal pins.
module tb_iter_alu;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  in2 = '0;
    logic [2:0]    select = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W:0]    out;
    logic          zero;
    logic          div_by_zero;
    logic          busy;
    logic [1:0]    state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [W+1:0]  exp_q[$];
    logic [W:0]    last_out;
    logic          last_zero;
    logic          last_dbz;

    iter_alu #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .select(select), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zero(zero), .div_by_zero(div_by_zero),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Expected {div_by_zero, out} from the arithmetic definition of each op.
    function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua, ub, r;
        logic d;
        ua = a; ub = b; d = 1'b0; r = 0;
        case (op)
            3'd0: r = ua + ub;
            3'd1: r = (ua + 32'h20000 - ub) & 32'h1FFFF;
            3'd2: if (ub == 0) begin r = 32'hFFFF; d = 1'b1; end else r = ua / ub;
            3'd3: if (ub == 0) begin r = ua; d = 1'b1; end else r = ua % ub;
            3'd4: r = ua & ub;
            3'd5: r = ua | ub;
            3'd6: r = ua ^ ub;
            default: r = (~(ua ^ ub)) & 32'hFFFF;
        endcase
        model = {d, r[W:0]};
    endfunction

    // Compare process: every cycle the result is valid it must match the head.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                chk("out", 32'(out), 32'(exp_q[0][W:0]));
                chk("zero", 32'(zero), 32'(exp_q[0][W-1:0] == '0));
                chk("div_by_zero", 32'(div_by_zero), 32'(exp_q[0][W+1]));
            end
        end
    end

    always @(posedge clock) begin
        if (!reset && out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        int t, lat, bcnt, exp_lat, exp_busy;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clock); t++; end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1; select = op; in1 = a; in2 = b;
        exp_q.push_back(model(op, a, b));
        exp_busy = ((op == 3'd2 || op == 3'd3) && b != 0) ? W : 0;
        exp_lat  = exp_busy + 1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in1 = W'($urandom); in2 = W'($urandom); select = 3'($urandom);
        lat = 0; bcnt = 0;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            if (busy) bcnt++;
            if (out_valid) break;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(bcnt), 32'(exp_busy));
        last_out = out; last_zero = zero; last_dbz = div_by_zero;
        for (int i = 0; i < stall; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            in1 = W'($urandom); in2 = W'($urandom); select = 3'($urandom);
            in_valid = 1'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
        chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    endtask

    logic [2:0]   t_op[8]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd2, 3'd3, 3'd2};
    logic [W-1:0] t_a[8]   = '{16'h8000, 16'h0000, 16'hF0F0, 16'h1200, 16'hAAAA, 16'hFFFF, 16'hFFFF, 16'h0003};
    logic [W-1:0] t_b[8]   = '{16'h8000, 16'h0001, 16'h3C3C, 16'h0034, 16'hAAAA, 16'h0001, 16'h0100, 16'h0007};

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        issue(3'd0, 16'hFFFF, 16'h0001, 0);
        chk("add_carry_out", 32'(last_out), 32'h10000);
        chk("add_carry_zero", 32'(last_zero), 32'd1);
        chk("add_carry_dbz", 32'(last_dbz), 32'd0);

        issue(3'd1, 16'd5, 16'd7, 1);
        chk("sub_borrow_out", 32'(last_out), 32'h1FFFE);
        chk("sub_borrow_zero", 32'(last_zero), 32'd0);
        issue(3'd1, 16'd7, 16'd5, 0);
        chk("sub_pos_out", 32'(last_out), 32'h00002);

        issue(3'd2, 16'd100, 16'd7, 0);
        chk("div_out", 32'(last_out), 32'd14);
        issue(3'd3, 16'd100, 16'd7, 2);
        chk("mod_out", 32'(last_out), 32'd2);

        issue(3'd2, 16'h1234, 16'h0000, 0);
        chk("div0_out", 32'(last_out), 32'h0FFFF);
        chk("div0_dbz", 32'(last_dbz), 32'd1);
        issue(3'd3, 16'h1234, 16'h0000, 0);
        chk("mod0_out", 32'(last_out), 32'h01234);
        chk("mod0_dbz", 32'(last_dbz), 32'd1);

        issue(3'd7, 16'h00FF, 16'h0F0F, 5);
        chk("xnor_held_out", 32'(last_out), 32'h0F00F);

        for (int i = 0; i < 8; i++) issue(t_op[i], t_a[i], t_b[i], i % 3);

        // Abort a divide at step 8 with reset.
        @(negedge clock);
        in_valid = 1'b1; select = 3'd2; in1 = 16'hFFFF; in2 = 16'd3;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1 reset = 1'b1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        issue(3'd0, 16'd2, 16'd3, 0);
        chk("post_abort_add", 32'(last_out), 32'd5);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
